mul_sequencer: RTL and testbench

//  Issue-side sequencer for the RV64M multiply path. Accepts a decoded MUL/MULH/MULHSU/MULHU/MULW op over a

---
 rtl/mul_pkg.sv | 34 +++
 rtl/mul_sequencer_if.sv | 31 +++
 rtl/mul_result_cache.sv | 71 +++++++
 rtl/mul_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mul_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the RV64M multiply issue path.
//   mul_op_t          - multiply flavour, encoded as funct3[1:0]
//   mul_seq_state_t   - sequencer FSM states
//   mul_op_signedness - {arg1_is_signed, arg2_is_signed} for an op
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_seq_state_t;

    // MUL only uses the low half, which does not depend on signedness, so it
    // runs unsigned like MULHU.
    function automatic logic [1:0] mul_op_signedness(input mul_op_t op);
        logic [1:0] sign_s;
        case (op)
            MULH:    sign_s = 2'b11;
            MULHSU:  sign_s = 2'b10;
            MULHU:   sign_s = 2'b00;
            MUL:     sign_s = 2'b00;
            default: sign_s = 2'b00;
        endcase
        return sign_s;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: issue (in_*) and writeback (out_*) handshakes of the
// multiply sequencer.
//   master - the issuing pipeline: drives the op and out_ready
//   slave  - the sequencer: drives in_ready and the held result
// Parameters width/tag_width must match the mul_sequencer instance.
interface mul_sequencer_if #(
    parameter int width     = 64,
    parameter int tag_width = 5
);
    logic                  in_valid;
    logic                  in_ready;
    mul_pkg::mul_op_t      in_op;
    logic                  in_is_w;
    logic [width-1:0]      in_rs1;
    logic [width-1:0]      in_rs2;
    logic [tag_width-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [width-1:0]      out_result;
    logic [tag_width-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_is_w, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_is_w, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_result_cache.sv
// mul_result_cache: single-entry memo of the last non-W multiply
// (rs1, rs2, signedness pair, low half, high half). Only built when
// MUL_RESULT_CACHE_EN is defined.
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   clear             - drops the entry (pipeline flush)
//   lookup_*          - key of the op being accepted; hit is combinational
//   fill_*            - entry write on a completed non-W multiply
//   hit, mul, mulh    - lookup result and stored product halves
`ifdef MUL_RESULT_CACHE_EN
module mul_result_cache #(
    parameter int width = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [width-1:0] lookup_rs1,
    input  logic [width-1:0] lookup_rs2,
    input  logic [1:0]       lookup_sign,
    input  logic             lookup_is_mul,
    input  logic             lookup_is_w,
    input  logic             fill_en,
    input  logic [width-1:0] fill_rs1,
    input  logic [width-1:0] fill_rs2,
    input  logic [1:0]       fill_sign,
    input  logic [width-1:0] fill_mul,
    input  logic [width-1:0] fill_mulh,
    output logic             hit,
    output logic [width-1:0] mul,
    output logic [width-1:0] mulh
);
    logic             valid_r;
    logic [width-1:0] rs1_r;
    logic [width-1:0] rs2_r;
    logic [1:0]       sign_r;
    logic [width-1:0] mul_r;
    logic [width-1:0] mulh_r;

    // Entry storage: cleared by reset/clear, overwritten on every fill.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid_r <= 1'b0;
            rs1_r   <= '0;
            rs2_r   <= '0;
            sign_r  <= 2'b00;
            mul_r   <= '0;
            mulh_r  <= '0;
        end else if (fill_en) begin
            valid_r <= 1'b1;
            rs1_r   <= fill_rs1;
            rs2_r   <= fill_rs2;
            sign_r  <= fill_sign;
            mul_r   <= fill_mul;
            mulh_r  <= fill_mulh;
        end
    end

    // Lookup: MUL's low half matches regardless of the stored signedness.
    always_comb begin
        hit = 1'b0;
        if (valid_r && !lookup_is_w && (lookup_rs1 == rs1_r) && (lookup_rs2 == rs2_r)
            && (lookup_is_mul || (lookup_sign == sign_r))) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    assign mul  = mul_r;
    assign mulh = mulh_r;
endmodule
`endif

// File: rtl/mul_sequencer.sv
// mul_sequencer: issue-side sequencer for the RV64M multiply path. Accepts
// MUL/MULH/MULHSU/MULHU/MULW, runs booth_multiplier_multi_cycle, captures its
// result in the single cycle it is valid and holds it for writeback.
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   flush                - abandon in-flight op and held result
//   io (slave)           - in_* issue handshake, out_* writeback handshake
//   mul_start            - multiplier start, high exactly in RUN
//   mul_arg1/2, *_is_signed - latched operands and signedness from the op
//   mulw_busy, mul_busy, mulw, mul, mulh - multiplier status and results
// Optional feature: MUL_RESULT_CACHE_EN adds a one-entry result cache; an
// accepted op that hits goes straight to DONE without starting the multiplier.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int width     = 64,
    parameter int tag_width = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    mul_sequencer_if.slave   io,
    output logic             mul_start,
    output logic [width-1:0] mul_arg1,
    output logic [width-1:0] mul_arg2,
    output logic             mul_arg1_is_signed,
    output logic             mul_arg2_is_signed,
    input  logic             mulw_busy,
    input  logic             mul_busy,
    input  logic [width-1:0] mulw,
    input  logic [width-1:0] mul,
    input  logic [width-1:0] mulh
);
    mul_seq_state_t       state_r;
    mul_seq_state_t       next_state_s;
    logic [width-1:0]     rs1_r;
    logic [width-1:0]     rs2_r;
    mul_op_t              op_r;
    logic                 is_w_r;
    logic [tag_width-1:0] tag_r;
    logic [width-1:0]     out_result_r;
    logic [tag_width-1:0] out_tag_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 capture_s;
    logic [width-1:0]     capture_val_s;
    logic [1:0]           op_sign_s;
    logic                 hit_s;
    logic [width-1:0]     hit_val_s;

    // MULW runs as an unsigned 32x32 multiply; only the low word matters.
    assign op_sign_s = is_w_r ? 2'b00 : mul_op_signedness(op_r);

`ifdef MUL_RESULT_CACHE_EN
    logic [1:0]       lookup_sign_s;
    logic [width-1:0] cache_mul_s;
    logic [width-1:0] cache_mulh_s;

    assign lookup_sign_s = mul_op_signedness(io.in_op);

    mul_result_cache #(.width(width)) u_cache (
        .clock         (clock),
        .reset         (reset),
        .clear         (flush),
        .lookup_rs1    (io.in_rs1),
        .lookup_rs2    (io.in_rs2),
        .lookup_sign   (lookup_sign_s),
        .lookup_is_mul (io.in_op == MUL),
        .lookup_is_w   (io.in_is_w),
        .fill_en       (capture_s && !is_w_r),
        .fill_rs1      (rs1_r),
        .fill_rs2      (rs2_r),
        .fill_sign     (op_sign_s),
        .fill_mul      (mul),
        .fill_mulh     (mulh),
        .hit           (hit_s),
        .mul           (cache_mul_s),
        .mulh          (cache_mulh_s)
    );

    assign hit_val_s = (io.in_op == MUL) ? cache_mul_s : cache_mulh_s;
`else
    assign hit_s     = 1'b0;
    assign hit_val_s = '0;
`endif

    // Next-state, handshake and capture decode. reset/flush dominate so nothing
    // is accepted or captured in those cycles.
    always_comb begin
        next_state_s  = state_r;
        in_ready_s    = 1'b0;
        accept_s      = 1'b0;
        capture_s     = 1'b0;
        capture_val_s = '0;
        if (reset || flush) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_s = 1'b1;
                    if (io.in_valid) begin
                        accept_s     = 1'b1;
                        next_state_s = hit_s ? DONE : RUN;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RUN: begin
                    // The multiplier result is only valid in the cycle busy drops.
                    if (is_w_r) begin
                        if (!mulw_busy) begin
                            capture_s     = 1'b1;
                            capture_val_s = mulw;
                            next_state_s  = DONE;
                        end else begin
                            next_state_s  = RUN;
                        end
                    end else begin
                        if (!mul_busy) begin
                            capture_s     = 1'b1;
                            capture_val_s = (op_r == MUL) ? mul : mulh;
                            next_state_s  = DONE;
                        end else begin
                            next_state_s  = RUN;
                        end
                    end
                end
                DONE: begin
                    // A new op may slip in on the same edge the result leaves.
                    in_ready_s = io.out_ready;
                    if (io.out_ready) begin
                        if (io.in_valid) begin
                            accept_s     = 1'b1;
                            next_state_s = hit_s ? DONE : RUN;
                        end else begin
                            next_state_s = IDLE;
                        end
                    end else begin
                        next_state_s = DONE;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // State, operand latch and held-result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            rs1_r        <= '0;
            rs2_r        <= '0;
            op_r         <= MUL;
            is_w_r       <= 1'b0;
            tag_r        <= '0;
            out_result_r <= '0;
            out_tag_r    <= '0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                rs1_r  <= io.in_rs1;
                rs2_r  <= io.in_rs2;
                op_r   <= io.in_op;
                is_w_r <= io.in_is_w;
                tag_r  <= io.in_tag;
            end
            if (capture_s) begin
                out_result_r <= capture_val_s;
                out_tag_r    <= tag_r;
            end else if (accept_s && hit_s) begin
                out_result_r <= hit_val_s;
                out_tag_r    <= io.in_tag;
            end
        end
    end

    // Everything below decodes registered state only; DONE keeps start low for
    // at least one cycle so the multiplier's round counter rewinds.
    assign io.in_ready          = in_ready_s;
    assign io.out_valid         = (state_r == DONE);
    assign io.out_result        = out_result_r;
    assign io.out_tag           = out_tag_r;
    assign mul_start            = (state_r == RUN);
    assign mul_arg1             = rs1_r;
    assign mul_arg2             = rs2_r;
    assign mul_arg1_is_signed   = op_sign_s[1];
    assign mul_arg2_is_signed   = op_sign_s[0];
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: self-checking bench for mul_sequencer with a behavioural
// stand-in for booth_multiplier_multi_cycle (busy drops after 32 start cycles
// for the 64-bit product, 16 for MULW; outputs are garbage otherwise).
module tb_mul_sequencer;
    import mul_pkg::*;

`ifdef MUL_RESULT_CACHE_EN
    localparam bit cache_en = 1'b1;
`else
    localparam bit cache_en = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        mul_start;
    logic [63:0] mul_arg1, mul_arg2;
    logic        a1s, a2s;
    logic        mulw_busy, mul_busy;
    logic [63:0] m_mulw, m_mul, m_mulh;
    int          total = 0;
    int          bad = 0;

    mul_sequencer_if #(.width(64), .tag_width(5)) ifc ();

    mul_sequencer #(.width(64), .tag_width(5)) dut (
        .clock(clock), .reset(reset), .flush(flush), .io(ifc),
        .mul_start(mul_start), .mul_arg1(mul_arg1), .mul_arg2(mul_arg2),
        .mul_arg1_is_signed(a1s), .mul_arg2_is_signed(a2s),
        .mulw_busy(mulw_busy), .mul_busy(mul_busy),
        .mulw(m_mulw), .mul(m_mul), .mulh(m_mulh)
    );

    always #5 clock = ~clock;

    // ---------------- multiplier stand-in ----------------
    logic [5:0]   mcnt = 6'd0;
    logic [127:0] xa, xb, prod;
    logic [31:0]  p32;
    always @(posedge clock) mcnt <= mul_start ? mcnt + 6'd1 : 6'd0;
    assign mul_busy  = mul_start && (mcnt < 6'd32);
    assign mulw_busy = mul_start && (mcnt < 6'd16);
    always_comb begin
        xa   = a1s ? {{64{mul_arg1[63]}}, mul_arg1} : {64'd0, mul_arg1};
        xb   = a2s ? {{64{mul_arg2[63]}}, mul_arg2} : {64'd0, mul_arg2};
        prod = xa * xb;
        p32  = mul_arg1[31:0] * mul_arg2[31:0];
    end
    assign m_mul  = (mul_start && !mul_busy)  ? prod[63:0]   : 64'hdead_beef_dead_beef;
    assign m_mulh = (mul_start && !mul_busy)  ? prod[127:64] : 64'hbad0_bad0_bad0_bad0;
    assign m_mulw = (mul_start && !mulw_busy) ? {{32{p32[31]}}, p32} : 64'h5a5a_5a5a_5a5a_5a5a;

    // ---------------- reference model ----------------
    logic        c_valid = 1'b0;
    logic [63:0] c_a, c_b;
    logic [1:0]  c_sign;

    function automatic logic [63:0] ref_result(input mul_op_t op, input logic is_w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic [31:0]         w;
        if (is_w) begin
            w = a[31:0] * b[31:0];
            return {{32{w[31]}}, w};
        end
        case (op)
            MUL:     begin up = a * b; return up[63:0]; end
            MULH:    begin sp = $signed(a) * $signed(b); return sp[127:64]; end
            MULHSU:  begin sp = $signed(a) * $signed({1'b0, b}); return sp[127:64]; end
            default: begin up = a * b; return up[127:64]; end
        endcase
    endfunction

    function automatic logic [1:0] ref_sign(input mul_op_t op);
        if (op == MULH) return 2'b11;
        else if (op == MULHSU) return 2'b10;
        else return 2'b00;
    endfunction

    function automatic bit model_hit(input mul_op_t op, input logic is_w,
                                     input logic [63:0] a, input logic [63:0] b);
        return cache_en && !is_w && c_valid && a == c_a && b == c_b &&
               (op == MUL || ref_sign(op) == c_sign);
    endfunction

    function automatic int exp_lat(input mul_op_t op, input logic is_w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (is_w) return 18;
        if (model_hit(op, is_w, a, b)) return 1;
        return 34;
    endfunction

    task automatic model_commit(input mul_op_t op, input logic is_w,
                                input logic [63:0] a, input logic [63:0] b);
        if (!is_w && !model_hit(op, is_w, a, b)) begin
            c_valid = 1'b1; c_a = a; c_b = b; c_sign = ref_sign(op);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic present(input mul_op_t op, input logic is_w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
        ifc.in_valid = 1'b1; ifc.in_op = op; ifc.in_is_w = is_w;
        ifc.in_rs1 = a; ifc.in_rs2 = b; ifc.in_tag = tag;
    endtask

    // Called #1 after the accept edge; lat counts edges from accept (inclusive).
    task automatic wait_result(output int lat, output logic [63:0] res,
                               output logic [4:0] rtag, output logic saw_start);
        lat = -1; res = '0; rtag = '0; saw_start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (mul_start) saw_start = 1'b1;
            if (ifc.out_valid) begin lat = k; break; end
            @(posedge clock); #1;
        end
        if (lat > 0) begin res = ifc.out_result; rtag = ifc.out_tag; end
    endtask

    task automatic do_op(input mul_op_t op, input logic is_w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, output int lat,
                         output logic [63:0] res, output logic [4:0] rtag, output logic saw_start);
        int n;
        lat = -1; res = '0; rtag = '0; saw_start = 1'b0;
        @(negedge clock);
        present(op, is_w, a, b, tag);
        #1;
        n = 0;
        while (!ifc.in_ready && n < 200) begin @(negedge clock); #1; n++; end
        if (!ifc.in_ready) begin ifc.in_valid = 1'b0; return; end
        @(posedge clock); #1;
        ifc.in_valid = 1'b0;
        ifc.in_rs1 = {$urandom, $urandom}; ifc.in_rs2 = {$urandom, $urandom};
        ifc.in_op = mul_op_t'($urandom_range(0, 3));
        wait_result(lat, res, rtag, saw_start);
    endtask

    task automatic drain();
        @(negedge clock); ifc.out_ready = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clock); present(MULH, 1'b0, 64'd9, 64'd9, 5'd3); #1;
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ifc.out_valid); end
        total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start got=%b want=0", mul_start); end
        total++; if (ifc.out_result !== 64'd0) begin bad++; $display("FAIL reset_out_result got=%h want=0", ifc.out_result); end
        total++; if (ifc.out_tag !== 5'd0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", ifc.out_tag); end
        total++; if (mul_arg1 !== 64'd0 || a1s !== 1'b0) begin bad++; $display("FAIL reset_args got=%h/%b want=0/0", mul_arg1, a1s); end
        ifc.in_valid = 1'b0;
        @(negedge clock); reset = 1'b0; #1;
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", ifc.in_ready); end
    endtask

    task automatic test_mulhu_max();
        int l; logic [63:0] r; logic [4:0] t; logic s;
        do_op(MULHU, 1'b0, 64'hffffffffffffffff, 64'hffffffffffffffff, 5'd1, l, r, t, s);
        total++; if (r !== 64'hfffffffffffffffe) begin bad++; $display("FAIL mulhu_result got=%h want=fffffffffffffffe", r); end
        total++; if (l !== 34) begin bad++; $display("FAIL mulhu_latency got=%0d want=34", l); end
        model_commit(MULHU, 1'b0, 64'hffffffffffffffff, 64'hffffffffffffffff);
    endtask

    task automatic test_signedness();
        int l; logic [63:0] r; logic [4:0] t; logic s;
        mul_op_t ops[3] = '{MULH, MULHSU, MULHU};
        logic [63:0] want[3] = '{64'hffffffffffffffff, 64'hffffffffffffffff, 64'h1};
        for (int i = 0; i < 3; i++) begin
            int el;
            el = exp_lat(ops[i], 1'b0, 64'hffffffffffffffff, 64'h2);
            do_op(ops[i], 1'b0, 64'hffffffffffffffff, 64'h2, 5'(i + 4), l, r, t, s);
            total++; if (r !== want[i]) begin bad++; $display("FAIL sign_%s_result got=%h want=%h", ops[i].name(), r, want[i]); end
            total++; if (l !== el) begin bad++; $display("FAIL sign_%s_latency got=%0d want=%0d", ops[i].name(), l, el); end
            model_commit(ops[i], 1'b0, 64'hffffffffffffffff, 64'h2);
        end
    endtask

    task automatic test_mulw();
        int l; logic [63:0] r; logic [4:0] t; logic s;
        do_op(MULHU, 1'b1, 64'h7fffffff, 64'h2, 5'h1b, l, r, t, s);
        total++; if (r !== 64'hfffffffffffffffe) begin bad++; $display("FAIL mulw_result got=%h want=fffffffffffffffe", r); end
        total++; if (l !== 18) begin bad++; $display("FAIL mulw_latency got=%0d want=18", l); end
        total++; if (t !== 5'h1b) begin bad++; $display("FAIL mulw_tag got=%h want=1b", t); end
    endtask

    task automatic test_backpressure();
        int l; logic [63:0] r; logic [4:0] t; logic s;
        drain();
        ifc.out_ready = 1'b0;
        do_op(MUL, 1'b0, 64'd3, 64'd5, 5'd7, l, r, t, s);
        total++; if (r !== 64'hf || l !== 34) begin bad++; $display("FAIL hold_first got=%h/%0d want=f/34", r, l); end
        model_commit(MUL, 1'b0, 64'd3, 64'd5);
        @(negedge clock); present(MUL, 1'b0, 64'd7, 64'd6, 5'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            total++; if (ifc.out_result !== 64'hf || ifc.out_valid !== 1'b1 || ifc.out_tag !== 5'd7) begin
                bad++; $display("FAIL hold_stable got=%h/%b/%h want=f/1/07", ifc.out_result, ifc.out_valid, ifc.out_tag); end
            total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%b want=0", ifc.in_ready); end
        end
        @(negedge clock); ifc.out_ready = 1'b1; #1;
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", ifc.in_ready); end
        @(posedge clock); #1; ifc.in_valid = 1'b0;
        wait_result(l, r, t, s);
        total++; if (r !== 64'h2a) begin bad++; $display("FAIL queued_result got=%h want=2a", r); end
        total++; if (l !== 34) begin bad++; $display("FAIL queued_latency got=%0d want=34", l); end
        total++; if (t !== 5'd8) begin bad++; $display("FAIL queued_tag got=%h want=08", t); end
        model_commit(MUL, 1'b0, 64'd7, 64'd6);
    endtask

    task automatic test_flush();
        int l, spurious; logic [63:0] r; logic [4:0] t; logic s;
        drain();
        @(negedge clock); present(MUL, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9); #1;
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL flush_pre_accept got=%b want=1", ifc.in_ready); end
        @(posedge clock); #1; ifc.in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock); flush = 1'b1; present(MUL, 1'b0, 64'd11, 64'd13, 5'd10); #1;
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", ifc.in_ready); end
        @(posedge clock); #1; flush = 1'b0; ifc.in_valid = 1'b0;
        c_valid = 1'b0;
        total++; if (ifc.out_valid !== 1'b0 || mul_start !== 1'b0) begin
            bad++; $display("FAIL flush_idle got=%b/%b want=0/0", ifc.out_valid, mul_start); end
        spurious = 0;
        repeat (40) begin @(posedge clock); #1; if (ifc.out_valid) spurious++; end
        total++; if (spurious !== 0) begin bad++; $display("FAIL flush_no_output got=%0d want=0", spurious); end
        do_op(MUL, 1'b0, 64'd2, 64'd3, 5'd11, l, r, t, s);
        total++; if (r !== 64'h6 || l !== 34) begin bad++; $display("FAIL after_flush got=%h/%0d want=6/34", r, l); end
        model_commit(MUL, 1'b0, 64'd2, 64'd3);
    endtask

    task automatic test_reset_mid_run();
        drain();
        @(negedge clock); present(MULHU, 1'b0, 64'd21, 64'd22, 5'd12);
        @(posedge clock); #1; ifc.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); #1;
        total++; if (ifc.out_valid !== 1'b0 || mul_start !== 1'b0 || ifc.in_ready !== 1'b0) begin
            bad++; $display("FAIL midrun_reset_ctl got=%b/%b/%b want=0/0/0", ifc.out_valid, mul_start, ifc.in_ready); end
        total++; if (mul_arg1 !== 64'd0 || ifc.out_result !== 64'd0) begin
            bad++; $display("FAIL midrun_reset_regs got=%h/%h want=0/0", mul_arg1, ifc.out_result); end
        reset = 1'b0; c_valid = 1'b0;
    endtask

    task automatic test_cache();
        int l, el; logic [63:0] r, a, b; logic [4:0] t; logic s;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        el = exp_lat(MULH, 1'b0, a, b);
        do_op(MULH, 1'b0, a, b, 5'd13, l, r, t, s);
        total++; if (r !== ref_result(MULH, 1'b0, a, b) || l !== el) begin
            bad++; $display("FAIL cache_fill got=%h/%0d want=%h/%0d", r, l, ref_result(MULH, 1'b0, a, b), el); end
        model_commit(MULH, 1'b0, a, b);
        do_op(MUL, 1'b0, a, b, 5'd14, l, r, t, s);
        total++; if (r !== ref_result(MUL, 1'b0, a, b)) begin bad++; $display("FAIL cache_mul_result got=%h want=%h", r, ref_result(MUL, 1'b0, a, b)); end
        total++; if (l !== (cache_en ? 1 : 34)) begin bad++; $display("FAIL cache_mul_latency got=%0d want=%0d", l, cache_en ? 1 : 34); end
        total++; if (s !== !cache_en) begin bad++; $display("FAIL cache_mul_start got=%b want=%b", s, !cache_en); end
        total++; if (t !== 5'd14) begin bad++; $display("FAIL cache_mul_tag got=%h want=0e", t); end
        model_commit(MUL, 1'b0, a, b);
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0; c_valid = 1'b0;
        do_op(MUL, 1'b0, a, b, 5'd15, l, r, t, s);
        total++; if (r !== ref_result(MUL, 1'b0, a, b) || l !== 34) begin
            bad++; $display("FAIL cache_after_flush got=%h/%0d want=%h/34", r, l, ref_result(MUL, 1'b0, a, b)); end
        model_commit(MUL, 1'b0, a, b);
    endtask

    task automatic test_back_to_back();
        int l, el; logic [63:0] r, a, b, er; logic [4:0] t, tg; logic s, w;
        mul_op_t op;
        a = 64'd1; b = 64'd1;
        for (int i = 0; i < 30; i++) begin
            op = mul_op_t'($urandom_range(0, 3));
            w  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) a[63] = 1'b1;
            end
            tg = 5'($urandom_range(0, 31));
            er = ref_result(op, w, a, b);
            el = exp_lat(op, w, a, b);
            do_op(op, w, a, b, tg, l, r, t, s);
            total++; if (r !== er) begin bad++; $display("FAIL rand%0d_result op=%s w=%b got=%h want=%h", i, op.name(), w, r, er); end
            total++; if (l !== el) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, l, el); end
            total++; if (t !== tg) begin bad++; $display("FAIL rand%0d_tag got=%h want=%h", i, t, tg); end
            model_commit(op, w, a, b);
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_op = MUL; ifc.in_is_w = 1'b0;
        ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_tag = '0; ifc.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        test_reset();
        test_mulhu_max();
        test_signedness();
        test_mulw();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        test_cache();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
